pipe_hazard_ctrl: RTL and testbench

PIPE_HAZARD_CTRL -- requirements
Module: pipe_hazard_ctrl

---
 rtl/pipe_hazard_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_pipe_hazard_ctrl.sv | 314 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/pipe_hazard_ctrl.sv
// Pipeline hazard controller: load-use interlock, redirect flush and MUL/DIV freeze
// with a bounded wait, plus saturating stall/flush event counters.
module pipe_hazard_ctrl #(
    parameter int unsigned MD_TIMEOUT = 64
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [4:0]  id_rs1,
    input  logic [4:0]  id_rs2,
    input  logic        id_uses_rs1,
    input  logic        id_uses_rs2,
    input  logic [4:0]  ex_rd,
    input  logic        ex_mem_read,
    input  logic        ex_redirect,
    input  logic        ex_md_start,
    input  logic        md_done,
    output logic        pc_enable,
    output logic        if_id_enable,
    output logic        id_ex_enable,
    output logic        ex_mem_enable,
    output logic        if_id_flush,
    output logic        id_ex_flush,
    output logic        ex_mem_flush,
    output logic [15:0] stall_cnt,
    output logic [15:0] flush_cnt,
    output logic        md_err
);

    typedef enum logic [1:0] {
        ST_RUN     = 2'd0,
        ST_MD_WAIT = 2'd1,
        ST_ERR     = 2'd2
    } state_t;

    // Last wait-counter value still spent in MD_WAIT before giving up.
    localparam logic [15:0] WAIT_LAST = 16'(MD_TIMEOUT - 1);

    state_t      r_state;
    state_t      w_state_nxt;
    logic [15:0] r_wait_cnt;
    logic [15:0] r_stall_cnt;
    logic [15:0] r_flush_cnt;
    logic        r_md_err;

    logic w_load_use;
    logic w_rs1_hit;
    logic w_rs2_hit;
    logic w_timeout;
    logic w_md_enter;
    logic w_md_waiting;
    logic w_redirect_evt;

    assign w_rs1_hit  = id_uses_rs1 && (id_rs1 == ex_rd);
    assign w_rs2_hit  = id_uses_rs2 && (id_rs2 == ex_rd);
    assign w_load_use = ex_mem_read && (ex_rd != 5'd0) && (w_rs1_hit || w_rs2_hit);
    assign w_timeout  = (r_wait_cnt == WAIT_LAST);

    // Redirect outranks a MUL/DIV start, which outranks a load-use stall.
    assign w_redirect_evt = (r_state == ST_RUN) && ex_redirect;
    assign w_md_enter     = (r_state == ST_RUN) && !ex_redirect && ex_md_start;
    assign w_md_waiting   = (r_state == ST_MD_WAIT) && !md_done;

    // State register
    always_ff @(posedge clk) begin
        // NOTE: rst is tested inside the clocked block only, so reset takes effect on a
        // clock edge; all sequential state uses non-blocking assignments to avoid races.
        if (!rst) begin
            r_state <= ST_RUN;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state logic
    always_comb begin
        // NOTE: default assignment first so no path through the case leaves a latch.
        w_state_nxt = r_state;
        unique case (r_state)
            ST_RUN: begin
                if (w_md_enter) begin
                    w_state_nxt = ST_MD_WAIT;
                end
            end
            ST_MD_WAIT: begin
                if (md_done) begin
                    w_state_nxt = ST_RUN;
                end else if (w_timeout) begin
                    w_state_nxt = ST_ERR;
                end
            end
            ST_ERR: begin
                w_state_nxt = ST_ERR;
            end
            default: begin
                w_state_nxt = ST_RUN;
            end
        endcase
    end

    // Output logic; everything held low while reset is asserted.
    always_comb begin
        pc_enable     = 1'b0;
        if_id_enable  = 1'b0;
        id_ex_enable  = 1'b0;
        ex_mem_enable = 1'b0;
        if_id_flush   = 1'b0;
        id_ex_flush   = 1'b0;
        ex_mem_flush  = 1'b0;
        if (rst) begin
            unique case (r_state)
                ST_RUN: begin
                    if (ex_redirect) begin
                        pc_enable     = 1'b1;
                        if_id_enable  = 1'b1;
                        id_ex_enable  = 1'b1;
                        ex_mem_enable = 1'b1;
                        if_id_flush   = 1'b1;
                        id_ex_flush   = 1'b1;
                    end else if (ex_md_start) begin
                        ex_mem_enable = 1'b1;
                        ex_mem_flush  = 1'b1;
                    end else if (w_load_use) begin
                        id_ex_enable  = 1'b1;
                        ex_mem_enable = 1'b1;
                        id_ex_flush   = 1'b1;
                    end else begin
                        pc_enable     = 1'b1;
                        if_id_enable  = 1'b1;
                        id_ex_enable  = 1'b1;
                        ex_mem_enable = 1'b1;
                    end
                end
                ST_MD_WAIT: begin
                    if (md_done) begin
                        pc_enable     = 1'b1;
                        if_id_enable  = 1'b1;
                        id_ex_enable  = 1'b1;
                        ex_mem_enable = 1'b1;
                    end else begin
                        ex_mem_enable = 1'b1;
                        ex_mem_flush  = 1'b1;
                    end
                end
                default: begin
                    // ERR (and any illegal encoding) keeps the whole pipeline frozen.
                end
            endcase
        end
    end

    // MUL/DIV wait counter and sticky timeout flag
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_wait_cnt <= 16'd0;
            r_md_err   <= 1'b0;
        end else begin
            if (w_md_enter) begin
                r_wait_cnt <= 16'd0;
            end else if (w_md_waiting) begin
                r_wait_cnt <= r_wait_cnt + 16'd1;
            end
            if (w_md_waiting && w_timeout) begin
                r_md_err <= 1'b1;
            end
        end
    end

    // Saturating event counters
    always_ff @(posedge clk) begin
        if (!rst) begin
            r_stall_cnt <= 16'd0;
            r_flush_cnt <= 16'd0;
        end else begin
            if (!pc_enable && (r_stall_cnt != 16'hFFFF)) begin
                r_stall_cnt <= r_stall_cnt + 16'd1;
            end
            if (w_redirect_evt && (r_flush_cnt != 16'hFFFF)) begin
                r_flush_cnt <= r_flush_cnt + 16'd1;
            end
        end
    end

    assign stall_cnt = r_stall_cnt;
    assign flush_cnt = r_flush_cnt;
    assign md_err    = r_md_err;

endmodule

// File: tb/tb_pipe_hazard_ctrl.sv
// Self-checking bench for pipe_hazard_ctrl: per-cycle stimulus with expected control
// words queued on drive and popped for comparison when the outputs are sampled.
module tb_pipe_hazard_ctrl;

    localparam int unsigned MD_TIMEOUT = 8;

    // {pc_en, if_id_en, id_ex_en, ex_mem_en, if_id_fl, id_ex_fl, ex_mem_fl}
    localparam logic [6:0] C_RUN   = 7'b1111_000;
    localparam logic [6:0] C_REDIR = 7'b1111_110;
    localparam logic [6:0] C_MDFRZ = 7'b0001_001;
    localparam logic [6:0] C_LDUSE = 7'b0011_010;
    localparam logic [6:0] C_OFF   = 7'b0000_000;

    typedef struct packed {
        logic       rst;
        logic [4:0] rs1;
        logic       u1;
        logic [4:0] rs2;
        logic       u2;
        logic [4:0] rd;
        logic       mr;
        logic       redir;
        logic       mds;
        logic       mdd;
    } stim_t;

    logic        clk = 1'b0;
    logic        rst;
    logic [4:0]  id_rs1, id_rs2, ex_rd;
    logic        id_uses_rs1, id_uses_rs2, ex_mem_read, ex_redirect, ex_md_start, md_done;
    logic        pc_enable, if_id_enable, id_ex_enable, ex_mem_enable;
    logic        if_id_flush, id_ex_flush, ex_mem_flush;
    logic [15:0] stall_cnt, flush_cnt;
    logic        md_err;

    logic [6:0]  exp_q[$];
    int          n_checks = 0;
    int          n_pass   = 0;
    logic [15:0] exp_stall = 16'd0;
    logic [15:0] exp_flush = 16'd0;

    wire [6:0] w_ctrl = {pc_enable, if_id_enable, id_ex_enable, ex_mem_enable,
                         if_id_flush, id_ex_flush, ex_mem_flush};

    always #5 clk = ~clk;

    pipe_hazard_ctrl #(.MD_TIMEOUT(MD_TIMEOUT)) dut (
        .clk          (clk),
        .rst          (rst),
        .id_rs1       (id_rs1),
        .id_rs2       (id_rs2),
        .id_uses_rs1  (id_uses_rs1),
        .id_uses_rs2  (id_uses_rs2),
        .ex_rd        (ex_rd),
        .ex_mem_read  (ex_mem_read),
        .ex_redirect  (ex_redirect),
        .ex_md_start  (ex_md_start),
        .md_done      (md_done),
        .pc_enable    (pc_enable),
        .if_id_enable (if_id_enable),
        .id_ex_enable (id_ex_enable),
        .ex_mem_enable(ex_mem_enable),
        .if_id_flush  (if_id_flush),
        .id_ex_flush  (id_ex_flush),
        .ex_mem_flush (ex_mem_flush),
        .stall_cnt    (stall_cnt),
        .flush_cnt    (flush_cnt),
        .md_err       (md_err)
    );

    function automatic stim_t mk(input logic r, input logic [4:0] rs1, input logic u1,
                                 input logic [4:0] rs2, input logic u2, input logic [4:0] rd,
                                 input logic mr, input logic redir, input logic mds,
                                 input logic mdd);
        stim_t s;
        s.rst = r; s.rs1 = rs1; s.u1 = u1; s.rs2 = rs2; s.u2 = u2; s.rd = rd;
        s.mr = mr; s.redir = redir; s.mds = mds; s.mdd = mdd;
        return s;
    endfunction

    stim_t idle;
    stim_t in_rst;

    task automatic drive(input stim_t s);
        rst         = s.rst;
        id_rs1      = s.rs1;
        id_uses_rs1 = s.u1;
        id_rs2      = s.rs2;
        id_uses_rs2 = s.u2;
        ex_rd       = s.rd;
        ex_mem_read = s.mr;
        ex_redirect = s.redir;
        ex_md_start = s.mds;
        md_done     = s.mdd;
    endtask

    // One clock: drive at the falling edge, sample just before the rising edge,
    // return at the next falling edge with expected counters advanced.
    task automatic cyc(input stim_t s, input logic [6:0] e, output logic [6:0] got);
        drive(s);
        exp_q.push_back(e);
        #4;
        got = w_ctrl;
        @(negedge clk);
        if (!s.rst) begin
            exp_stall = 16'd0;
            exp_flush = 16'd0;
        end else begin
            if (!e[6] && exp_stall != 16'hFFFF) exp_stall = exp_stall + 16'd1;
            if (e == C_REDIR && exp_flush != 16'hFFFF) exp_flush = exp_flush + 16'd1;
        end
    endtask

    task automatic run_steps(input string name, input stim_t st[$], input logic [6:0] ex[$]);
        logic [6:0] got, e;
        for (int i = 0; i < st.size(); i++) begin
            cyc(st[i], ex[i], got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL %s step %0d: ctrl=%b expected %b", name, i, got, e);
            else n_pass++;
        end
    endtask

    task automatic test_reset();
        logic [6:0] got, e;
        for (int i = 0; i < 2; i++) begin
            cyc(mk(0, 5'd3, 1, 5'd3, 1, 5'd3, 1, 1, 1, 1), C_OFF, got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL reset_ctrl %0d: ctrl=%b expected %b", i, got, e);
            else n_pass++;
        end
        n_checks++;
        if ({stall_cnt, flush_cnt, md_err} !== {16'd0, 16'd0, 1'b0})
            $display("FAIL reset_state: stall=%0d flush=%0d md_err=%b expected 0/0/0",
                     stall_cnt, flush_cnt, md_err);
        else n_pass++;
    endtask

    task automatic test_run_default();
        stim_t st[$];
        logic [6:0] ex[$];
        st.push_back(idle);                                    ex.push_back(C_RUN);
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));        ex.push_back(C_RUN);
        st.push_back(mk(1, 5'd7, 1, 5'd7, 1, 5'd7, 0, 0, 0, 0)); ex.push_back(C_RUN);
        run_steps("run_default", st, ex);
        n_checks++;
        if (stall_cnt !== 16'd0) $display("FAIL run_stall: stall=%0d expected 0", stall_cnt);
        else n_pass++;
    endtask

    task automatic test_load_use();
        stim_t st[$];
        logic [6:0] ex[$];
        st.push_back(mk(1, 0, 0, 5'd5, 1, 5'd5, 1, 0, 0, 0));     ex.push_back(C_LDUSE);
        st.push_back(idle);                                      ex.push_back(C_RUN);
        run_steps("load_use_rs2", st, ex);
        n_checks++;
        if (stall_cnt !== 16'd1) $display("FAIL load_use_stall: stall=%0d expected 1", stall_cnt);
        else n_pass++;
        st.delete(); ex.delete();
        st.push_back(mk(1, 5'd7, 0, 5'd2, 1, 5'd7, 1, 0, 0, 0));  ex.push_back(C_RUN);
        st.push_back(mk(1, 5'd7, 1, 5'd3, 1, 5'd7, 1, 0, 0, 0));  ex.push_back(C_LDUSE);
        st.push_back(mk(1, 5'd31, 1, 5'd31, 0, 5'd31, 1, 0, 0, 0)); ex.push_back(C_LDUSE);
        st.push_back(idle);                                      ex.push_back(C_RUN);
        run_steps("load_use_rs1", st, ex);
        n_checks++;
        if (stall_cnt !== exp_stall) $display("FAIL load_use_cnt: stall=%0d expected %0d", stall_cnt, exp_stall);
        else n_pass++;
    endtask

    task automatic test_load_rd0();
        stim_t st[$];
        logic [6:0] ex[$];
        st.push_back(mk(1, 0, 1, 0, 1, 0, 1, 0, 0, 0));           ex.push_back(C_RUN);
        st.push_back(mk(1, 0, 1, 5'd4, 0, 0, 1, 0, 0, 0));        ex.push_back(C_RUN);
        run_steps("load_rd0", st, ex);
    endtask

    task automatic test_redirect();
        stim_t st[$];
        logic [6:0] ex[$];
        logic [15:0] stall_before;
        stall_before = exp_stall;
        st.push_back(mk(1, 0, 0, 5'd5, 1, 5'd5, 1, 1, 0, 0));     ex.push_back(C_REDIR);
        run_steps("redirect_loaduse", st, ex);
        n_checks++;
        if (flush_cnt !== 16'd1) $display("FAIL redirect_flush_cnt: flush=%0d expected 1", flush_cnt);
        else n_pass++;
        n_checks++;
        if (stall_cnt !== stall_before) $display("FAIL redirect_stall: stall=%0d expected %0d", stall_cnt, stall_before);
        else n_pass++;
        st.delete(); ex.delete();
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 0));           ex.push_back(C_REDIR);
        st.push_back(idle);                                      ex.push_back(C_RUN);
        run_steps("redirect_over_md", st, ex);
        n_checks++;
        if (flush_cnt !== 16'd2) $display("FAIL redirect_flush_cnt2: flush=%0d expected 2", flush_cnt);
        else n_pass++;
    endtask

    task automatic test_md_wait();
        stim_t st[$];
        logic [6:0] ex[$];
        logic [15:0] stall_before, flush_before;
        stall_before = exp_stall;
        flush_before = exp_flush;
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));           ex.push_back(C_MDFRZ);
        for (int i = 0; i < 3; i++) begin
            st.push_back(mk(1, 5'd9, 1, 0, 0, 5'd9, 1, 1, 1, 0)); ex.push_back(C_MDFRZ);
        end
        st.push_back(mk(1, 5'd9, 1, 0, 0, 5'd9, 1, 0, 0, 1));     ex.push_back(C_RUN);
        st.push_back(idle);                                      ex.push_back(C_RUN);
        run_steps("md_wait", st, ex);
        n_checks++;
        if (stall_cnt !== stall_before + 16'd4)
            $display("FAIL md_stall_cnt: stall=%0d expected %0d", stall_cnt, stall_before + 16'd4);
        else n_pass++;
        n_checks++;
        if (flush_cnt !== flush_before) $display("FAIL md_flush_cnt: flush=%0d expected %0d", flush_cnt, flush_before);
        else n_pass++;
    endtask

    task automatic test_reset_in_md();
        stim_t st[$];
        logic [6:0] ex[$];
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0));           ex.push_back(C_MDFRZ);
        st.push_back(idle);                                      ex.push_back(C_MDFRZ);
        st.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0, 1, 0));           ex.push_back(C_OFF);
        st.push_back(idle);                                      ex.push_back(C_RUN);
        st.push_back(idle);                                      ex.push_back(C_RUN);
        run_steps("reset_in_md", st, ex);
        n_checks++;
        if ({stall_cnt, flush_cnt} !== {16'd0, 16'd0})
            $display("FAIL reset_in_md_cnt: stall=%0d flush=%0d expected 0/0", stall_cnt, flush_cnt);
        else n_pass++;
    endtask

    task automatic test_timeout();
        stim_t st[$];
        logic [6:0] ex[$];
        logic [6:0] got, e;
        cyc(mk(1, 0, 0, 0, 0, 0, 0, 0, 1, 0), C_MDFRZ, got);
        e = exp_q.pop_front();
        n_checks++;
        if (got !== e) $display("FAIL timeout_start: ctrl=%b expected %b", got, e);
        else n_pass++;
        for (int i = 0; i < int'(MD_TIMEOUT); i++) begin
            cyc(idle, C_MDFRZ, got);
            e = exp_q.pop_front();
            n_checks++;
            if (got !== e) $display("FAIL timeout_wait %0d: ctrl=%b expected %b", i, got, e);
            else n_pass++;
            if (i == int'(MD_TIMEOUT) - 2) begin
                n_checks++;
                if (md_err !== 1'b0) $display("FAIL md_err_early: md_err=%b expected 0", md_err);
                else n_pass++;
            end
        end
        n_checks++;
        if (md_err !== 1'b1) $display("FAIL md_err_set: md_err=%b expected 1", md_err);
        else n_pass++;
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 1, 1, 1));           ex.push_back(C_OFF);
        st.push_back(mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 1));           ex.push_back(C_OFF);
        run_steps("err_hold", st, ex);
        n_checks++;
        if (md_err !== 1'b1) $display("FAIL md_err_sticky: md_err=%b expected 1", md_err);
        else n_pass++;
        // Sit in ERR long enough for the stall counter to reach its ceiling.
        for (int i = 0; i < 65536; i++) begin
            cyc(idle, C_OFF, got);
            e = exp_q.pop_front();
            if (got !== e) begin
                n_checks++;
                $display("FAIL err_freeze cycle %0d: ctrl=%b expected %b", i, got, e);
            end
        end
        n_checks++;
        if (stall_cnt !== 16'hFFFF || exp_stall !== 16'hFFFF)
            $display("FAIL stall_saturate: stall=%h expected ffff", stall_cnt);
        else n_pass++;
        st.delete(); ex.delete();
        st.push_back(idle);                                      ex.push_back(C_OFF);
        st.push_back(in_rst);                                    ex.push_back(C_OFF);
        run_steps("err_reset", st, ex);
        n_checks++;
        if ({stall_cnt, flush_cnt, md_err} !== {16'd0, 16'd0, 1'b0})
            $display("FAIL err_reset_state: stall=%0d flush=%0d md_err=%b expected 0/0/0",
                     stall_cnt, flush_cnt, md_err);
        else n_pass++;
        st.delete(); ex.delete();
        st.push_back(idle);                                      ex.push_back(C_RUN);
        run_steps("after_err_reset", st, ex);
    endtask

    initial begin
        idle   = mk(1, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        in_rst = mk(0, 0, 0, 0, 0, 0, 0, 0, 0, 0);
        drive(in_rst);
        @(negedge clk);
        test_reset();
        test_run_default();
        test_load_use();
        test_load_rd0();
        test_redirect();
        test_md_wait();
        test_reset_in_md();
        test_timeout();
        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
